// File: rtl/fi_pkg.sv
// fi_pkg: shared fault-mode encodings, slot state type and sizing helper
// for the AXI read-data fault injector.
package fi_pkg;

  localparam logic [1:0] FI_FLIP   = 2'd0;
  localparam logic [1:0] FI_STUCK0 = 2'd1;
  localparam logic [1:0] FI_STUCK1 = 2'd2;
  localparam logic [1:0] FI_DISARM = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } fi_slot_state_t;

  // Width of a slot index; a single slot still needs one bit.
  function automatic int fi_slot_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

endpackage

// File: rtl/fi_slot.sv
// fi_slot: one fault slot -- config registers, trigger match and per-mode
// mask outputs.
//
// state  | meaning
// IDLE   | disarmed, never applies its mask
// ARMED  | waiting for the beat whose index equals trigger
// ACTIVE | permanent fault, mask applied on every cycle while enabled
// DONE   | transient fault has fired, inert until reconfigured
module fi_slot
  import fi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fi_enable,
  input  logic              s_rvalid,
  input  logic              beat,
  input  logic [CNT_W-1:0]  beat_count,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_trigger,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_persist,
  output logic              fire,
  output logic [DATA_W-1:0] flip_mask,
  output logic [DATA_W-1:0] zero_mask,
  output logic [DATA_W-1:0] one_mask
);

  fi_slot_state_t    state;
  logic [CNT_W-1:0]  trigger;
  logic [DATA_W-1:0] mask;
  logic [1:0]        mode;
  logic              persist;
  logic              match;
  logic              apply;

  // Reset suppresses the fault in the same cycle so the pass-through stays clean.
  assign match = !reset && fi_enable && (state == ARMED) && (beat_count == trigger);
  assign fire  = match && beat;
  // Applying on valid rather than on beat keeps data stable while ready is low.
  assign apply = (match && s_rvalid) || (!reset && fi_enable && (state == ACTIVE));

  assign flip_mask = (apply && (mode == FI_FLIP))   ? mask : '0;
  assign zero_mask = (apply && (mode == FI_STUCK0)) ? mask : '0;
  assign one_mask  = (apply && (mode == FI_STUCK1)) ? mask : '0;

  // Slot state machine; a cfg write wins over a simultaneous firing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      trigger <= '0;
      mask    <= '0;
      mode    <= FI_FLIP;
      persist <= 1'b0;
    end else if (cfg_we) begin
      trigger <= cfg_trigger;
      mask    <= cfg_mask;
      mode    <= cfg_mode;
      persist <= cfg_persist;
      state   <= (cfg_mode == FI_DISARM) ? IDLE : ARMED;
    end else if (fire) begin
      state <= persist ? ACTIVE : DONE;
    end
  end

endmodule

// File: rtl/fi_rdata_injector.sv
// fi_rdata_injector: AXI R-channel pass-through that corrupts rdata on
// programmed beats and reports each injection to the campaign scoreboard.
module fi_rdata_injector
  import fi_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int NUM_SLOTS = 4,
  parameter  int CNT_W     = 32,
  localparam int SLOT_W    = fi_slot_w(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fi_enable,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              m_rvalid,
  input  logic              m_rready,
  output logic [DATA_W-1:0] m_rdata,
  input  logic              cfg_valid,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [CNT_W-1:0]  cfg_trigger,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_persist,
  output logic [CNT_W-1:0]  beat_count,
  output logic              hit_valid,
  output logic [SLOT_W-1:0] hit_slot,
  output logic [CNT_W-1:0]  hit_beat
);

  logic                 beat;
  logic [NUM_SLOTS-1:0] fire;
  logic [DATA_W-1:0]    flip_m [NUM_SLOTS];
  logic [DATA_W-1:0]    zero_m [NUM_SLOTS];
  logic [DATA_W-1:0]    one_m  [NUM_SLOTS];
  logic [DATA_W-1:0]    f_all;
  logic [DATA_W-1:0]    z_all;
  logic [DATA_W-1:0]    o_all;
  logic [SLOT_W-1:0]    fire_idx;

  assign m_rvalid = s_rvalid;
  assign s_rready = m_rready;
  assign beat     = s_rvalid && m_rready;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    fi_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .fi_enable   (fi_enable),
      .s_rvalid    (s_rvalid),
      .beat        (beat),
      .beat_count  (beat_count),
      .cfg_we      (cfg_valid && (cfg_slot == SLOT_W'(i))),
      .cfg_trigger (cfg_trigger),
      .cfg_mask    (cfg_mask),
      .cfg_mode    (cfg_mode),
      .cfg_persist (cfg_persist),
      .fire        (fire[i]),
      .flip_mask   (flip_m[i]),
      .zero_mask   (zero_m[i]),
      .one_mask    (one_m[i])
    );
  end

  // Merge all applying slots; stuck-1 beats stuck-0 beats flip.
  always_comb begin
    f_all = '0;
    z_all = '0;
    o_all = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      f_all = f_all | flip_m[i];
      z_all = z_all | zero_m[i];
      o_all = o_all | one_m[i];
    end
    m_rdata = ((s_rdata ^ f_all) & ~z_all) | o_all;
  end

  // Lowest-index firing slot wins the report.
  always_comb begin
    fire_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (fire[i]) fire_idx = SLOT_W'(i);
    end
  end

  // Saturating beat counter and registered hit report.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count <= '0;
      hit_valid  <= 1'b0;
      hit_slot   <= '0;
      hit_beat   <= '0;
    end else begin
      if (beat && (beat_count != '1)) beat_count <= beat_count + CNT_W'(1);
      hit_valid <= |fire;
      if (|fire) begin
        hit_slot <= fire_idx;
        hit_beat <= beat_count;
      end
    end
  end

endmodule
